// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the signals between the pipeline control unit and the datapath.
//   master : datapath side. Drives the IF/ID fields (id_valid, id_opcode,
//            id_rs, id_rt), the ID/EX load destination ex_rt and the ALU
//            zero flag ex_zero; receives the control outputs.
//   slave  : control-unit side. Receives those inputs and drives the PC/IF-ID
//            enables, the flush/redirect flags, the EX/MEM/WB control words
//            and stall_count.
// ----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int OP_W   = 6,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [OP_W-1:0]   id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_zero;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              pc_src;
  logic              id_jump;
  logic              id_illegal;

  logic              ex_regDst;
  logic              ex_aluSrc;
  logic              ex_branch_eq;
  logic              ex_branch_ne;
  logic [1:0]        ex_aluOp;
  logic              ex_memRead;
  logic              ex_memWrite;
  logic              ex_memToReg;
  logic              ex_regWrite;

  logic              mem_memRead;
  logic              mem_memWrite;
  logic              mem_memToReg;
  logic              mem_regWrite;

  logic              wb_memToReg;
  logic              wb_regWrite;

  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_rt, ex_zero,
    input  pc_write, ifid_write, ifid_flush, pc_src, id_jump, id_illegal,
    input  ex_regDst, ex_aluSrc, ex_branch_eq, ex_branch_ne, ex_aluOp,
    input  ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite,
    input  mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite,
    input  wb_memToReg, wb_regWrite, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_rt, ex_zero,
    output pc_write, ifid_write, ifid_flush, pc_src, id_jump, id_illegal,
    output ex_regDst, ex_aluSrc, ex_branch_eq, ex_branch_ne, ex_aluOp,
    output ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite,
    output mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite,
    output wb_memToReg, wb_regWrite, stall_count
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined control unit: decodes the ID opcode, carries the control word
// through ID/EX, EX/MEM and MEM/WB, inserts LOAD_STALL bubbles on a load-use
// hazard and resolves branch (EX) / jump (ID) redirects with an IF/ID flush.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_ctrl_if.slave (ID/EX inputs, enables, flush, stage controls,
//           saturating stall_count)
// ----------------------------------------------------------------------------
module pipe_ctrl_unit #(
  parameter int OP_W       = 6,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);

  localparam int K_W = 2;

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
  } ctrl_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic regWrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic memToReg;
    logic regWrite;
  } wb_ctrl_t;

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  ctrl_t            ex_q, ex_d;
  mem_ctrl_t        mem_q;
  wb_ctrl_t         wb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t dec;
  logic  dec_jump, dec_known, uses_rt;
  logic  haz, pc_src, pc_write, ifid_write, ifid_flush, id_jump, bubble, cnt_inc;

  // Decode; an invalid ID slot decodes as a harmless all-zero word.
  always_comb begin
    dec       = '0;
    dec_jump  = 1'b0;
    dec_known = 1'b1;
    uses_rt   = 1'b0;
    case (bus.id_opcode)
      OP_LW:   begin dec.memRead = 1'b1; dec.memToReg = 1'b1; dec.aluSrc = 1'b1;
                     dec.regWrite = 1'b1; end
      OP_SW:   begin dec.memWrite = 1'b1; dec.aluSrc = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      OP_BEQ:  begin dec.branch_eq = 1'b1; dec.aluOp = 2'b01; uses_rt = 1'b1; end
      OP_BNE:  begin dec.branch_ne = 1'b1; dec.aluOp = 2'b01; uses_rt = 1'b1; end
      OP_R:    begin dec.regDst = 1'b1; dec.regWrite = 1'b1; dec.aluOp = 2'b10;
                     uses_rt = 1'b1; end
      OP_J:    dec_jump = 1'b1;
      default: dec_known = 1'b0;
    endcase
    if (!bus.id_valid) begin
      dec       = '0;
      dec_jump  = 1'b0;
      dec_known = 1'b1;
      uses_rt   = 1'b0;
    end
  end

  // Load in EX whose destination feeds the instruction in ID. r0 never hazards.
  assign haz = bus.id_valid & ex_q.memRead & (bus.ex_rt != '0) &
               ((bus.ex_rt == bus.id_rs) | ((bus.ex_rt == bus.id_rt) & uses_rt));

  assign pc_src = (ex_q.branch_eq & bus.ex_zero) | (ex_q.branch_ne & ~bus.ex_zero);

  // A taken branch squashes whatever ID holds, so it overrides any stall.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    id_jump    = 1'b0;
    bubble     = 1'b0;
    cnt_inc    = 1'b0;
    if (pc_src) begin
      ifid_flush = 1'b1;
      bubble     = 1'b1;
      state_d    = RUN;
      k_d        = '0;
    end else if (state_q == LU_STALL) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
      cnt_inc    = 1'b1;
      k_d        = k_q - K_W'(1);
      if (k_q == K_W'(1)) state_d = RUN;
    end else if (haz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
      cnt_inc    = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = LU_STALL;
        k_d     = K_W'(LOAD_STALL - 1);
      end
    end else if (dec_jump) begin
      id_jump    = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  assign ex_d  = bubble ? '0 : dec;
  assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      k_q     <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ex_q    <= ex_d;
      mem_q   <= '{ex_q.memRead, ex_q.memWrite, ex_q.memToReg, ex_q.regWrite};
      wb_q    <= '{mem_q.memToReg, mem_q.regWrite};
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.pc_src       = pc_src;
  assign bus.id_jump      = id_jump;
  assign bus.id_illegal   = bus.id_valid & ~dec_known;

  assign bus.ex_regDst    = ex_q.regDst;
  assign bus.ex_aluSrc    = ex_q.aluSrc;
  assign bus.ex_branch_eq = ex_q.branch_eq;
  assign bus.ex_branch_ne = ex_q.branch_ne;
  assign bus.ex_aluOp     = ex_q.aluOp;
  assign bus.ex_memRead   = ex_q.memRead;
  assign bus.ex_memWrite  = ex_q.memWrite;
  assign bus.ex_memToReg  = ex_q.memToReg;
  assign bus.ex_regWrite  = ex_q.regWrite;

  assign bus.mem_memRead  = mem_q.memRead;
  assign bus.mem_memWrite = mem_q.memWrite;
  assign bus.mem_memToReg = mem_q.memToReg;
  assign bus.mem_regWrite = mem_q.regWrite;

  assign bus.wb_memToReg  = wb_q.memToReg;
  assign bus.wb_regWrite  = wb_q.regWrite;

  assign bus.stall_count  = cnt_q;

endmodule
